// File: rtl/timer_bank_pkg.sv
// Shared register map, channel stride and CTRL bit layout for the timer bank.
package timer_bank_pkg;

    localparam logic [7:0] OFF_MSEC     = 8'h00;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h04;
    localparam logic [7:0] OFF_IRQ_EN   = 8'h08;
    localparam logic [7:0] CH_BASE      = 8'h20;
    localparam logic [7:0] CH_STRIDE    = 8'h10;

    localparam logic [3:0] CH_OFF_CTRL  = 4'h0;
    localparam logic [3:0] CH_OFF_LOAD  = 4'h4;
    localparam logic [3:0] CH_OFF_COUNT = 4'h8;

    localparam int CTRL_W    = 3;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_SRC  = 2;

    typedef enum logic [1:0] {
        CH_REG_CTRL  = 2'd0,
        CH_REG_LOAD  = 2'd1,
        CH_REG_COUNT = 2'd2,
        CH_REG_NONE  = 2'd3
    } ch_reg_e;

    function automatic ch_reg_e ch_reg_decode(input logic [3:0] off);
        case (off)
            CH_OFF_CTRL:  return CH_REG_CTRL;
            CH_OFF_LOAD:  return CH_REG_LOAD;
            CH_OFF_COUNT: return CH_REG_COUNT;
            default:      return CH_REG_NONE;
        endcase
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_bank_channel.sv
// One down-counting timer channel: CTRL/LOAD/COUNT registers and expiry detection.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              cpu_clk,
    input  logic              reset,
    input  logic              ms_tick,
    input  logic              wr_ctrl,
    input  logic              wr_load,
    input  logic [CTRL_W-1:0] wr_ctrl_value,
    input  logic [CNT_W-1:0]  wr_load_value,
    output logic [CTRL_W-1:0] ctrl,
    output logic [CNT_W-1:0]  load,
    output logic [CNT_W-1:0]  count,
    output logic              expire
);

    logic tick_sel;

    assign tick_sel = ctrl[CTRL_SRC] ? ms_tick : 1'b1;
    assign expire   = ctrl[CTRL_EN] && tick_sel && (count == '0);

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            ctrl  <= '0;
            load  <= '0;
            count <= '0;
        end else begin
            if (ctrl[CTRL_EN] && tick_sel) begin
                if (count != '0)
                    count <= count - 1'b1;
                else if (ctrl[CTRL_AUTO])
                    count <= load;
                else
                    ctrl[CTRL_EN] <= 1'b0;
            end
            if (wr_load)
                load <= wr_load_value;
            // A bus CTRL write is ordered last so it overrides expiry's EN clear.
            if (wr_ctrl) begin
                ctrl <= wr_ctrl_value;
                if (!ctrl[CTRL_EN] && wr_ctrl_value[CTRL_EN])
                    count <= load;
            end
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Timer bank: picorv32 bus slave, ms prescaler, MSEC counter, IRQ status/enable, N_CH channels.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int unsigned CLK_HZ = 27000000,
    parameter int          N_CH   = 4,
    parameter int          CNT_W  = 32
) (
    input  logic            cpu_clk,
    input  logic            reset,
    input  logic            mem_valid,
    input  logic [31:0]     mem_addr,
    input  logic [31:0]     mem_wdata,
    input  logic [3:0]      mem_wstrb,
    output logic            mem_ready,
    output logic [31:0]     mem_rdata,
    output logic [N_CH-1:0] irq
);

    localparam int unsigned PRE_DIV  = CLK_HZ / 1000;
    localparam int unsigned PRE_TERM = PRE_DIV - 1;
    localparam int          PRE_W    = $clog2(PRE_DIV);

    logic [PRE_W-1:0]  prescaler;
    logic              ms_tick;
    logic [31:0]       msec;
    logic [N_CH-1:0]   irq_stat;
    logic [N_CH-1:0]   irq_en;

    logic              bus_access;
    logic              wr_access;
    logic [7:0]        addr8;
    logic [7:0]        ch_rel;
    logic [7:0]        ch_idx;
    ch_reg_e           ch_reg;
    logic [31:0]       rd_val;
    logic [31:0]       wr_merged;
    logic [N_CH-1:0]   stat_clr;
    logic              en_wr;
    logic [N_CH-1:0]   wr_ctrl;
    logic [N_CH-1:0]   wr_load;
    logic [N_CH-1:0]   ch_expire;
    logic [CTRL_W-1:0] ch_ctrl  [N_CH];
    logic [CNT_W-1:0]  ch_load  [N_CH];
    logic [CNT_W-1:0]  ch_count [N_CH];
    logic              unused_bits;

    assign ms_tick     = (prescaler == PRE_W'(PRE_TERM));
    assign bus_access  = mem_valid && !mem_ready;
    assign wr_access   = bus_access && (mem_wstrb != '0);
    assign irq         = irq_stat & irq_en;
    assign unused_bits = ^{mem_addr[31:8], mem_addr[1:0], wr_merged};

    always_comb begin
        addr8    = {mem_addr[7:2], 2'b00};
        ch_rel   = addr8 - CH_BASE;
        ch_idx   = ch_rel / CH_STRIDE;
        ch_reg   = (addr8 >= CH_BASE) ? ch_reg_decode(ch_rel[3:0]) : CH_REG_NONE;
        rd_val   = '0;
        wr_ctrl  = '0;
        wr_load  = '0;
        case (addr8)
            OFF_MSEC:     rd_val = msec;
            OFF_IRQ_STAT: rd_val = 32'(irq_stat);
            OFF_IRQ_EN:   rd_val = 32'(irq_en);
            default:      ;
        endcase
        // Channels beyond N_CH never match, so they read 0 and ignore writes.
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (32'(ch_idx) == c) begin
                case (ch_reg)
                    CH_REG_CTRL:  rd_val = 32'(ch_ctrl[c]);
                    CH_REG_LOAD:  rd_val = 32'(ch_load[c]);
                    CH_REG_COUNT: rd_val = 32'(ch_count[c]);
                    default:      ;
                endcase
                wr_ctrl[c] = wr_access && (ch_reg == CH_REG_CTRL);
                wr_load[c] = wr_access && (ch_reg == CH_REG_LOAD);
            end
        end
        wr_merged = apply_wstrb(rd_val, mem_wdata, mem_wstrb);
        en_wr     = wr_access && (addr8 == OFF_IRQ_EN);
        stat_clr  = (wr_access && (addr8 == OFF_IRQ_STAT))
                    ? (mem_wdata[N_CH-1:0] & {N_CH{mem_wstrb[0]}}) : '0;
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            prescaler <= '0;
            msec      <= '0;
            irq_stat  <= '0;
            irq_en    <= '0;
        end else begin
            mem_ready <= bus_access;
            mem_rdata <= bus_access ? rd_val : '0;
            prescaler <= ms_tick ? '0 : prescaler + 1'b1;
            if (ms_tick)
                msec <= msec + 1'b1;
            irq_stat <= (irq_stat & ~stat_clr) | ch_expire;
            if (en_wr)
                irq_en <= wr_merged[N_CH-1:0];
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .cpu_clk       (cpu_clk),
            .reset         (reset),
            .ms_tick       (ms_tick),
            .wr_ctrl       (wr_ctrl[c]),
            .wr_load       (wr_load[c]),
            .wr_ctrl_value (wr_merged[CTRL_W-1:0]),
            .wr_load_value (wr_merged[CNT_W-1:0]),
            .ctrl          (ch_ctrl[c]),
            .load          (ch_load[c]),
            .count         (ch_count[c]),
            .expire        (ch_expire[c])
        );
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank (CLK_HZ=27000, N_CH=4, CNT_W=16).
module tb_timer_bank;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [3:0]  irq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc;
    int en_cyc;
    int rise1;
    int rise2;
    logic [3:0]  irq_ack;
    logic [31:0] rdat;

    timer_bank #(.CLK_HZ(27000), .N_CH(4), .CNT_W(16)) dut (
        .cpu_clk   (cpu_clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .irq       (irq)
    );

    always #5 cpu_clk = ~cpu_clk;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns one cycle after the ack cycle.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output logic [31:0] rdata);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        @(negedge cpu_clk);
        acc_cyc = cyc;
        irq_ack = irq;
        check("ready_high", 32'(mem_ready), 32'd1);
        rdata     = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(negedge cpu_clk);
        check("ready_one_cycle", 32'(mem_ready), 32'd0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        bus(addr, 32'h0, 4'h0, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] d;
        bus(addr, data, strb, d);
    endtask

    initial begin
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        repeat (3) @(negedge cpu_clk);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;

        // 270 idle cycles = 10 ms at 27 kHz
        repeat (270) @(negedge cpu_clk);
        rd(32'h00, 32'd10, "msec_after_270");

        // ch0 one-shot, LOAD=5
        wr(32'h08, 32'hF, 4'hF);
        wr(32'h24, 32'd5, 4'hF);
        wr(32'h20, 32'h1, 4'hF);
        rd(32'h28, 32'd4, "ch0_count_e2");
        rd(32'h28, 32'd2, "ch0_count_e4");
        check("ch0_irq_before_expiry", 32'(irq[0]), 32'd0);
        @(negedge cpu_clk);
        check("ch0_irq_6th_cycle", 32'(irq[0]), 32'd1);
        rd(32'h20, 32'h0, "ch0_en_cleared");
        rd(32'h28, 32'h0, "ch0_count_zero");
        rd(32'h04, 32'h1, "stat_ch0_set");
        bus(32'h04, 32'h1, 4'hF, rdat);
        check("w1c_returns_prewrite", rdat, 32'h1);
        rd(32'h04, 32'h0, "stat_ch0_cleared");

        // ch1 auto-reload on ms ticks, LOAD=2 -> period 3 ms
        wr(32'h34, 32'd2, 4'hF);
        wr(32'h30, 32'h7, 4'hF);
        en_cyc = acc_cyc;
        for (int i = 0; i < 200 && !irq[1]; i++) @(negedge cpu_clk);
        rise1 = cyc;
        check("ch1_first_rise_seen", 32'(irq[1]), 32'd1);
        check("ch1_first_rise_window",
              32'((rise1 - en_cyc >= 55) && (rise1 - en_cyc <= 81)), 32'd1);
        wr(32'h04, 32'h2, 4'hF);
        check("ch1_w1c_clears", 32'(irq_ack[1]), 32'd0);
        rd(32'h38, 32'd2, "ch1_reloaded");
        for (int i = 0; i < 200 && !irq[1]; i++) @(negedge cpu_clk);
        rise2 = cyc;
        check("ch1_second_rise_seen", 32'(irq[1]), 32'd1);
        check("ch1_period_cycles", 32'(rise2 - rise1), 32'd81);
        wr(32'h30, 32'h0, 4'hF);
        wr(32'h04, 32'h2, 4'hF);
        rd(32'h04, 32'h0, "stat_ch1_cleared");

        // ch2 byte strobes and truncation
        bus(32'h44, 32'h1234, 4'h1, rdat);
        check("ch2_load_prewrite0", rdat, 32'h0);
        rd(32'h44, 32'h34, "ch2_load_byte0");
        bus(32'h44, 32'hABCDE, 4'hF, rdat);
        check("ch2_load_prewrite1", rdat, 32'h34);
        rd(32'h44, 32'hBCDE, "ch2_load_trunc");

        // ch3 LOAD=0 AUTO=1 expires every cycle: set-wins and CTRL-wins
        wr(32'h50, 32'h3, 4'hF);
        rd(32'h04, 32'h8, "stat_ch3_set");
        wr(32'h04, 32'h8, 4'hF);
        check("ch3_set_wins_over_w1c", 32'(irq_ack[3]), 32'd1);
        rd(32'h04, 32'h8, "stat_ch3_still_set");
        wr(32'h50, 32'h2, 4'hF);
        rd(32'h50, 32'h2, "ch3_ctrl_write_wins");
        wr(32'h04, 32'h8, 4'hF);
        rd(32'h04, 32'h0, "stat_ch3_cleared");

        // Unmapped and out-of-range addresses
        wr(32'h60, 32'hFFFF_FFFF, 4'hF);
        wr(32'h0C, 32'hFFFF_FFFF, 4'hF);
        rd(32'h60, 32'h0, "read_0x60");
        rd(32'hFC, 32'h0, "read_0xFC");
        rd(32'h0C, 32'h0, "read_0x0C");

        // Reset in the middle of a transaction while ch0 counts
        wr(32'h24, 32'd100, 4'hF);
        wr(32'h20, 32'h1, 4'hF);
        mem_valid = 1'b1;
        mem_addr  = 32'h44;
        mem_wdata = 32'h5555;
        mem_wstrb = 4'hF;
        reset     = 1'b1;
        @(negedge cpu_clk);
        check("mid_rst_no_ready", 32'(mem_ready), 32'd0);
        check("mid_rst_rdata", mem_rdata, 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        @(negedge cpu_clk);
        check("mid_rst_no_ready2", 32'(mem_ready), 32'd0);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        reset     = 1'b0;
        rd(32'h00, 32'h0, "post_rst_msec");
        rd(32'h04, 32'h0, "post_rst_stat");
        rd(32'h08, 32'h0, "post_rst_irq_en");
        rd(32'h20, 32'h0, "post_rst_ch0_ctrl");
        rd(32'h24, 32'h0, "post_rst_ch0_load");
        rd(32'h28, 32'h0, "post_rst_ch0_count");
        rd(32'h44, 32'h0, "post_rst_ch2_load");
        rd(32'h50, 32'h0, "post_rst_ch3_ctrl");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter CLK_HZ, default 27000000, cpu_clk frequency in Hz; CLK_HZ/1000 SHALL be at least 2.
REQ-002 Parameter N_CH, default 4, number of timer channels (legal 1..8).
REQ-003 Parameter CNT_W, default 32, channel counter width (legal 8..32).
REQ-004 cpu_clk  in  1  sole clock; every flop SHALL be on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mem_valid  in  1  bus request (picorv32 native bus).
REQ-007 mem_addr  in  32  byte address; only bits [7:2] are decoded.
REQ-008 mem_wdata  in  32  write data.
REQ-009 mem_wstrb  in  4  byte write strobes; 0 = read.
REQ-010 mem_ready  out  1  one-cycle completion pulse.
REQ-011 mem_rdata  out  32  registered read data, valid while mem_ready=1.
REQ-012 irq  out  N_CH  per-channel interrupt level.

Function
REQ-013 Bus handshake: when mem_valid=1 and mem_ready=0, the block SHALL assert mem_ready for exactly one cycle on the next edge; write and read capture happen on that same edge.
REQ-014 Writes SHALL honour each mem_wstrb bit per byte; rdata SHALL return the pre-write value.
REQ-015 Register map: 0x00 MSEC (RO); 0x04 IRQ_STAT (W1C); 0x08 IRQ_EN (RW); channel c at 0x20+0x10*c: +0 CTRL, +4 LOAD, +8 COUNT (RO).
REQ-016 Unmapped and c>=N_CH addresses SHALL read 0, ignore writes, and still complete in 1 cycle.
REQ-017 A millisecond prescaler SHALL count 0..CLK_HZ/1000-1 and emit a 1-cycle ms_tick at the terminal value.
REQ-018 MSEC SHALL increment by 1 on each ms_tick and wrap from 0xFFFFFFFF to 0.
REQ-019 CTRL bits: [0] EN, [1] AUTO (auto-reload), [2] SRC (0 = every cpu_clk, 1 = ms_tick); other bits read 0.
REQ-020 LOAD and COUNT are CNT_W bits; writes truncate to CNT_W bits, reads zero-extend.
REQ-021 A CTRL write changing EN 0->1 SHALL set COUNT=LOAD on that edge; no decrement occurs on that edge.
REQ-022 While EN=1, each selected tick with COUNT!=0 SHALL decrement COUNT by 1.
REQ-023 A selected tick with COUNT==0 is an expiry: set IRQ_STAT[c]; if AUTO=1 then COUNT<=LOAD, else EN<=0 and COUNT stays 0.
REQ-024 LOAD=0 with AUTO=1 SHALL therefore expire on every selected tick.
REQ-025 An EN 1->0 write SHALL freeze COUNT at its current value.
REQ-026 An expiry in the same cycle as a W1C write to the same IRQ_STAT bit SHALL leave the bit set (set wins).
REQ-027 A CTRL write in the same cycle as that channel's expiry SHALL win for EN/AUTO/SRC; the IRQ_STAT bit SHALL still set.
REQ-028 irq[c] SHALL equal IRQ_STAT[c] AND IRQ_EN[c], driven from registers with no combinational path from bus inputs.

Reset
REQ-029 Under reset: mem_ready=0, mem_rdata=0, MSEC=0, prescaler=0, IRQ_STAT=0, IRQ_EN=0, all CTRL/LOAD/COUNT=0, and irq=0 on the next edge.
REQ-030 Reset asserted mid-transaction SHALL abort it with no register update and no mem_ready pulse.

Structure
REQ-031 A shared package timer_bank_pkg SHALL hold the register offsets, channel stride, and CTRL bit indices.
REQ-032 Sub-module timer_channel SHALL hold one channel's CTRL/LOAD/COUNT and expiry logic, instantiated N_CH times by generate.
REQ-033 The top level SHALL hold the bus decode, prescaler, MSEC, IRQ_STAT, and IRQ_EN.

Verification (CLK_HZ=27000, N_CH=4, CNT_W=16)
REQ-034 Reset, then idle for 270 cycles -> MSEC reads 10; every bus access completes with mem_ready high for exactly 1 cycle.
REQ-035 Write ch0 LOAD=5, then CTRL=0x1 -> COUNT reads 5,4,...,0; IRQ_STAT[0] sets on the 6th cycle after enable; EN then reads 0.
REQ-036 Write ch1 LOAD=2 and IRQ_EN=0x2, then CTRL=0x7 -> irq[1] rises 3 ms after enable; W1C 0x2 clears it; it rises again 3 ms later.
REQ-037 Write ch2 LOAD=0x1234 with wstrb=0x1 -> LOAD reads 0x0034; write 0xABCDE with wstrb=0xF -> LOAD reads 0xBCDE (truncated).
REQ-038 W1C IRQ_STAT bit 3 in the same cycle as ch3 expiry -> bit 3 reads 1; reads of 0x60 and 0xFC return 0.
REQ-039 Assert reset while ch0 is counting with mem_valid=1 -> no mem_ready pulse; all registers read their REQ-029 values afterwards.
